// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: request/response handshake and data-memory pins of the load/store unit.
// master is the execute/memory side, slave is the controller.
interface lsu_mem_ctrl_if #(parameter int ADDR_W = 32);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              mem_ce;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ce, mem_we, mem_addr, mem_wdata
   );
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ce, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store initiator; sub-word stores use read-modify-write.
// Define MISALIGN_CHECK_EN to flag misaligned halfword/word accesses instead of forcing alignment.
module lsu_mem_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 1024
) (
   input logic          clk,
   input logic          rst,
   lsu_mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
   state_t            state;
   logic              we_q;
   logic              uns_q;
   logic [1:0]        size_q;
   logic [1:0]        lo_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf;
   logic              word_sz;
   logic              misalign;
   logic              out_range;
   logic              err;
   logic [1:0]        eff_lo;
   logic [ADDR_W-1:0] word_addr;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       load_val;
   logic [31:0]       merged;
   always_comb begin
      word_sz   = bus.req_size[1];
`ifdef MISALIGN_CHECK_EN
      misalign  = word_sz ? |bus.req_addr[1:0] : bus.req_size[0] & bus.req_addr[0];
      eff_lo    = bus.req_addr[1:0];
`else
      misalign  = 1'b0;
      eff_lo    = word_sz ? 2'b00 : bus.req_size[0] ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
`endif
      word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
      out_range = word_addr >= ADDR_W'(MEM_BYTES - 3);
      err       = misalign | out_range;
   end
   // lane extraction works on the live read port so the result is ready with rsp_valid
   always_comb begin
      lane_b   = bus.mem_rdata[{lo_q, 3'b000} +: 8];
      lane_h   = bus.mem_rdata[{lo_q[1], 4'b0000} +: 16];
      load_val = size_q[1] ? bus.mem_rdata :
                 size_q[0] ? {{16{~uns_q & lane_h[15]}}, lane_h} :
                             {{24{~uns_q & lane_b[7]}}, lane_b};
      merged   = rbuf;
      if (size_q[0])
         merged[{lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      else
         merged[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
   end
   assign bus.mem_wdata = (state != WR) ? '0 : size_q[1] ? wdata_q : merged;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         we_q          <= 1'b0;
         uns_q         <= 1'b0;
         size_q        <= 2'd0;
         lo_q          <= 2'd0;
         wdata_q       <= '0;
         rbuf          <= '0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.mem_ce    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               we_q          <= bus.req_we;
               uns_q         <= bus.req_unsigned;
               size_q        <= bus.req_size;
               lo_q          <= eff_lo;
               wdata_q       <= bus.req_wdata;
               bus.req_ready <= 1'b0;
               bus.rsp_valid <= err;
               bus.rsp_err   <= err;
               bus.mem_ce    <= ~err;
               bus.mem_we    <= ~err & bus.req_we & word_sz;
               bus.mem_addr  <= 32'(word_addr);
               state         <= err ? RESP : (bus.req_we & word_sz) ? WR : RD;
            end
            RD: begin
               rbuf <= bus.mem_rdata;
               if (we_q) begin
                  bus.mem_we <= 1'b1;
                  state      <= WR;
               end else begin
                  bus.mem_ce    <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= load_val;
                  state         <= RESP;
               end
            end
            WR: begin
               bus.mem_ce    <= 1'b0;
               bus.mem_we    <= 1'b0;
               bus.rsp_valid <= 1'b1;
               state         <= RESP;
            end
            default: begin
               bus.rsp_valid <= 1'b0;
               bus.rsp_err   <= 1'b0;
               bus.req_ready <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed bench for lsu_mem_ctrl with a 1 KiB word memory model.
// Expectations follow MISALIGN_CHECK_EN when it is defined for the build.
module tb_lsu_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          errors = 0;
   int          checks = 0;
   int          lat, ce_n, we_n;
   logic [31:0] ma, mw, rd;
   logic        er, pv;
   logic [31:0] mem [256];

   lsu_mem_ctrl_if #(.ADDR_W(32)) bus();
   lsu_mem_ctrl #(.ADDR_W(32), .MEM_BYTES(1024)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;
   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
   always @(posedge clk) if (bus.mem_ce && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

   // issues one request from IDLE and gathers what happened until one cycle after rsp_valid
   task automatic run(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] wd);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_unsigned = un;
      bus.req_addr = a; bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1; ce_n = 0; we_n = 0; ma = 32'hx; mw = 32'hx;
      while (!bus.rsp_valid && lat < 8) begin
         if (bus.mem_ce) begin ce_n++; ma = bus.mem_addr; end
         if (bus.mem_we) begin we_n++; mw = bus.mem_wdata; end
         @(posedge clk); #1;
         lat++;
      end
      er = bus.rsp_err; rd = bus.rsp_rdata;
      @(posedge clk); #1;
      pv = bus.rsp_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
      repeat (3) @(posedge clk); #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.rsp_valid); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.rsp_err); end
      checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rsp_rdata); end
      checks++; if (bus.mem_ce !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_ce_we got %b%b exp 00", bus.mem_ce, bus.mem_we); end
      checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata); end
      rst = 1'b0; bus.req_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.req_ready !== 1'b1 || bus.mem_ce !== 1'b0) begin errors++; $display("FAIL rst_prio got ready=%b ce=%b exp 1/0", bus.req_ready, bus.mem_ce); end
   endtask

   task automatic test_store_word();
      run(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sw10_lat got %0d exp 2", lat); end
      checks++; if (ce_n !== 1 || we_n !== 1) begin errors++; $display("FAIL sw10_cycles got ce=%0d we=%0d exp 1/1", ce_n, we_n); end
      checks++; if (mw !== 32'h8899AABB || ma !== 32'h10) begin errors++; $display("FAIL sw10_bus got %h@%h exp 8899aabb@10", mw, ma); end
      checks++; if (pv !== 1'b0) begin errors++; $display("FAIL sw10_pulse got %b exp 0", pv); end
      run(1'b1, 2'd2, 1'b0, 32'h0C, 32'hDEADBEEF);
      checks++; if (lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL sw0c_lat_err got %0d/%b exp 2/0", lat, er); end
      checks++; if (ce_n !== 1 || we_n !== 1 || ma !== 32'h0C) begin errors++; $display("FAIL sw0c_cycles got ce=%0d we=%0d addr=%h exp 1/1/0c", ce_n, we_n, ma); end
      checks++; if (mem[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw0c_mem got %h exp deadbeef", mem[3]); end
   endtask

   task automatic test_load();
      run(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
      checks++; if (rd !== 32'hFFFFFFAA || lat !== 2) begin errors++; $display("FAIL lb_s got %h lat %0d exp ffffffaa lat 2", rd, lat); end
      checks++; if (ce_n !== 1 || we_n !== 0 || ma !== 32'h10) begin errors++; $display("FAIL lb_s_cycles got ce=%0d we=%0d addr=%h exp 1/0/10", ce_n, we_n, ma); end
      run(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
      checks++; if (rd !== 32'h000000AA || lat !== 2) begin errors++; $display("FAIL lb_u got %h lat %0d exp 000000aa lat 2", rd, lat); end
      run(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
      checks++; if (rd !== 32'hFFFF8899) begin errors++; $display("FAIL lh_s got %h exp ffff8899", rd); end
      run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      checks++; if (rd !== 32'h8899AABB || er !== 1'b0) begin errors++; $display("FAIL lw got %h err %b exp 8899aabb err 0", rd, er); end
      run(1'b0, 2'd3, 1'b0, 32'h0C, 32'h0);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_size3 got %h exp deadbeef", rd); end
      run(1'b0, 2'd0, 1'b1, 32'h0F, 32'h0);
      checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lb_0f got %h exp 000000de", rd); end
      run(1'b0, 2'd0, 1'b0, 32'h0C, 32'h0);
      checks++; if (rd !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_0c got %h exp ffffffef", rd); end
   endtask

   task automatic test_store_subword();
      run(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFFFF55);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sb_lat got %0d exp 3", lat); end
      checks++; if (ce_n !== 2 || we_n !== 1) begin errors++; $display("FAIL sb_cycles got ce=%0d we=%0d exp 2/1", ce_n, we_n); end
      checks++; if (mw !== 32'h8855AABB || ma !== 32'h10) begin errors++; $display("FAIL sb_bus got %h@%h exp 8855aabb@10", mw, ma); end
      run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      checks++; if (rd !== 32'h8855AABB) begin errors++; $display("FAIL sb_reload got %h exp 8855aabb", rd); end
      run(1'b1, 2'd1, 1'b0, 32'h0E, 32'hABCD1234);
      checks++; if (lat !== 3 || mw !== 32'h1234BEEF) begin errors++; $display("FAIL sh_0e got %h lat %0d exp 1234beef lat 3", mw, lat); end
      checks++; if (mem[3] !== 32'h1234BEEF) begin errors++; $display("FAIL sh_mem got %h exp 1234beef", mem[3]); end
   endtask

   task automatic test_misalign();
      run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      run(1'b0, 2'd1, 1'b1, 32'h13, 32'h0);
`ifdef MISALIGN_CHECK_EN
      checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL mis_h got lat %0d err %b exp 1/1", lat, er); end
      checks++; if (ce_n !== 0 || rd !== 32'h8855AABB) begin errors++; $display("FAIL mis_h_side got ce=%0d rd=%h exp 0/8855aabb", ce_n, rd); end
      run(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
      checks++; if (lat !== 1 || er !== 1'b1 || ce_n !== 0) begin errors++; $display("FAIL mis_w got lat %0d err %b ce %0d exp 1/1/0", lat, er, ce_n); end
`else
      checks++; if (rd !== 32'h00008855 || er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL mis_h got %h err %b lat %0d exp 00008855/0/2", rd, er, lat); end
      run(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
      checks++; if (rd !== 32'h8855AABB || er !== 1'b0) begin errors++; $display("FAIL mis_w got %h err %b exp 8855aabb/0", rd, er); end
`endif
   endtask

   task automatic test_out_of_range();
      run(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D);
      checks++; if (er !== 1'b0 || mem[255] !== 32'hCAFEF00D) begin errors++; $display("FAIL top_word got err %b mem %h exp 0/cafef00d", er, mem[255]); end
      run(1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0);
      checks++; if (rd !== 32'h000000CA || er !== 1'b0) begin errors++; $display("FAIL top_byte got %h err %b exp 000000ca/0", rd, er); end
      run(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
      checks++; if (lat !== 1 || er !== 1'b1 || ce_n !== 0) begin errors++; $display("FAIL oor_ld got lat %0d err %b ce %0d exp 1/1/0", lat, er, ce_n); end
      checks++; if (rd !== 32'h000000CA) begin errors++; $display("FAIL oor_rdata got %h exp 000000ca", rd); end
      run(1'b1, 2'd0, 1'b0, 32'h401, 32'h11);
      checks++; if (er !== 1'b1 || we_n !== 0 || pv !== 1'b0) begin errors++; $display("FAIL oor_st got err %b we %0d pulse %b exp 1/0/0", er, we_n, pv); end
   endtask

   task automatic test_back_to_back();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0; bus.req_addr = 32'h10;
      @(posedge clk); #1;
      checks++; if (bus.req_ready !== 1'b0 || bus.mem_ce !== 1'b1) begin errors++; $display("FAIL b2b_rd got ready=%b ce=%b exp 0/1", bus.req_ready, bus.mem_ce); end
      bus.req_addr = 32'h0C;
      @(posedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_rdata !== 32'h8855AABB) begin errors++; $display("FAIL b2b_rsp1 got v=%b r=%b d=%h exp 1/0/8855aabb", bus.rsp_valid, bus.req_ready, bus.rsp_rdata); end
      @(posedge clk); #1;
      checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_ce !== 1'b0) begin errors++; $display("FAIL b2b_idle got r=%b v=%b ce=%b exp 1/0/0", bus.req_ready, bus.rsp_valid, bus.mem_ce); end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      checks++; if (bus.mem_ce !== 1'b1 || bus.mem_addr !== 32'h0C) begin errors++; $display("FAIL b2b_rd2 got ce=%b addr=%h exp 1/0c", bus.mem_ce, bus.mem_addr); end
      @(posedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1234BEEF) begin errors++; $display("FAIL b2b_rsp2 got v=%b d=%h exp 1/1234beef", bus.rsp_valid, bus.rsp_rdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int v, w;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_addr = 32'h10; bus.req_wdata = 32'h77;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      checks++; if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL mid_rd got ce=%b we=%b exp 1/0", bus.mem_ce, bus.mem_we); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (bus.req_ready !== 1'b1 || bus.mem_ce !== 1'b0) begin errors++; $display("FAIL mid_ready got r=%b ce=%b exp 1/0", bus.req_ready, bus.mem_ce); end
      v = int'(bus.rsp_valid); w = int'(bus.mem_we);
      repeat (4) begin @(posedge clk); #1; v += int'(bus.rsp_valid); w += int'(bus.mem_we); end
      checks++; if (v !== 0 || w !== 0) begin errors++; $display("FAIL mid_quiet got valid=%0d we=%0d exp 0/0", v, w); end
      checks++; if (mem[4] !== 32'h8855AABB) begin errors++; $display("FAIL mid_mem got %h exp 8855aabb", mem[4]); end
      run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      checks++; if (rd !== 32'h8855AABB || lat !== 2) begin errors++; $display("FAIL mid_after got %h lat %0d exp 8855aabb lat 2", rd, lat); end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load();
      test_store_subword();
      test_misalign();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator sitting between the execute stage and the byte-addressable data memory.
- Accepts one load or store request at a time and drives the memory's ce/we/addr/data_i pins.
- Samples the memory's combinational read port, then returns a sign- or zero-extended load result, or a store completion.
- Sub-word stores are performed as read-modify-write, because the memory only writes full 32-bit little-endian words.

Parameters:
- ADDR_W, 32, width of the byte address.
- MEM_BYTES, 1024, addressable bytes. Word addresses at or above MEM_BYTES-3 are out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; held until the next response.
- rsp_err  out  1  misaligned or out-of-range access; valid with rsp_valid.
- mem_ce  out  1  to memory chip enable.
- mem_we  out  1  to memory write enable.
- mem_addr  out  32  to memory; always word-aligned (addr & ~3).
- mem_wdata  out  32  to memory write data.
- mem_rdata  in  32  from memory; combinational read data.

Behaviour:
- Reset:
  - state = IDLE; latched request registers, read buffer and rsp_rdata = 0.
  - rsp_valid = 0, rsp_err = 0, req_ready = 1, mem_ce = mem_we = 0, mem_addr = mem_wdata = 0.
- Handshake: request accepted when req_valid && req_ready at a rising edge. Inputs are latched at that edge and not used afterwards.
- req_ready = 1 only in IDLE. There is no back-to-back acceptance: a new request is accepted no earlier than the cycle after rsp_valid.
- Memory-side outputs decode only from the state register and latched registers, never from req_* inputs.
- States:
  - IDLE: wait for a request. On accept:
    - error -> RESP
    - word store -> WR
    - otherwise -> RD
  - RD:
    - Drive mem_ce=1, mem_we=0, mem_addr=word address.
    - Capture mem_rdata into the read buffer at the edge.
    - Next state: RESP for a load, WR for a sub-word store.
  - WR:
    - Drive mem_ce=1, mem_we=1, mem_addr=word address.
    - mem_wdata = full req_wdata for a word store.
    - For a sub-word store, mem_wdata = read buffer with the selected lane replaced: byte lane = addr[1:0]; halfword lane = addr[1] (bits 15:0 or 31:16).
    - Next state: RESP.
  - RESP:
    - rsp_valid=1 for exactly one cycle; rsp_err valid.
    - For loads, rsp_rdata is loaded with the extracted lane, extended per req_unsigned/req_size.
    - Next state: IDLE.
- Latency from the accept edge (cycle N) to rsp_valid:
  - load: N+2
  - word store: N+2
  - sub-word store: N+3
  - error: N+1
- mem_ce is high for exactly one cycle per load or word store, and two cycles per sub-word store (RD, then WR).
- Out-of-range word address: rsp_err=1, no memory cycle, rsp_rdata unchanged.
- On an error response rsp_rdata is unchanged.
- Reset mid-operation: state returns to IDLE, no rsp_valid.
  - Reset in WR: the write on that edge still happens (memory is not reset).
  - Reset in RD: no write ever issues.
- rst has priority over a concurrent req_valid.

Optional Feature:
- MISALIGN_CHECK_EN defined:
  - halfword with addr[0]=1, or word with addr[1:0]!=0, is an error.
  - rsp_err=1 at N+1, no memory cycle.
- MISALIGN_CHECK_EN undefined:
  - low address bits are forced to alignment (halfword clears addr[0], word clears addr[1:0]) and the access proceeds.
  - rsp_err is asserted only for out-of-range accesses.

Test Plan:
- Preload word 0x10 = 0x8899AABB; load byte signed at 0x11 -> rsp_rdata=0xFFFFFFAA at N+2. Same with unsigned -> 0x000000AA. mem_ce high 1 cycle, mem_we never high.
- Load halfword signed at 0x12 -> 0xFFFF8899. Load word at 0x10 -> 0x8899AABB.
- Store byte 0x55 to 0x12 -> RD then WR with mem_addr=0x10, mem_wdata=0x8855AABB. rsp_valid at N+3; subsequent word load at 0x10 returns 0x8855AABB.
- Store word 0xDEADBEEF to 0x0C -> single WR cycle with mem_addr=0x0C, mem_we=1. rsp_valid at N+2, rsp_err=0. Bytes 0x0C..0x0F = EF,BE,AD,DE.
- With MISALIGN_CHECK_EN: halfword load at 0x13 -> rsp_valid and rsp_err=1 at N+1, mem_ce never high, rsp_rdata unchanged. Without the macro: the same load reads 0x12 -> 0xFFFF8899 (after the earlier byte store 0x55: 0x00008855 unsigned).
- Sub-word store to 0x10, assert rst during RD -> no mem_we pulse, no rsp_valid. req_ready=1 the cycle after reset; memory unchanged.
